// File: rtl/hazard_pipe_ctrl_if.sv
// hazard_pipe_ctrl_if: ID-stage operand/destination bundle and the controller's responses.
// Latency: none, this is only a wiring bundle.
// Backpressure: stall_out/pc_hold_out are the only hold signals carried back to the core.
//
// Ports (master = core ID/EX side, slave = hazard controller):
//   id_*_in, redirect_in          core -> controller
//   stall_out, pc_hold_out,
//   flush_if_out, flush_id_out,
//   fwd_sel_a/b_out,
//   stage_valid_out,
//   stall/flush_count_out         controller -> core
interface hazard_pipe_ctrl_if #(
   parameter int REG_W = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 32
);
   logic             id_valid_in;
   logic [REG_W-1:0] id_rs_in;
   logic [REG_W-1:0] id_rt_in;
   logic             id_use_rs_in;
   logic             id_use_rt_in;
   logic             id_we_in;
   logic [REG_W-1:0] id_dst_in;
   logic             id_load_in;
   logic             redirect_in;

   logic             stall_out;
   logic             pc_hold_out;
   logic             flush_if_out;
   logic             flush_id_out;
   logic [2:0]       fwd_sel_a_out;
   logic [2:0]       fwd_sel_b_out;
   logic [DEPTH-1:0] stage_valid_out;
   logic [CNT_W-1:0] stall_count_out;
   logic [CNT_W-1:0] flush_count_out;

   modport master (
      output id_valid_in, id_rs_in, id_rt_in, id_use_rs_in, id_use_rt_in,
             id_we_in, id_dst_in, id_load_in, redirect_in,
      input  stall_out, pc_hold_out, flush_if_out, flush_id_out,
             fwd_sel_a_out, fwd_sel_b_out, stage_valid_out,
             stall_count_out, flush_count_out
   );

   modport slave (
      input  id_valid_in, id_rs_in, id_rt_in, id_use_rs_in, id_use_rt_in,
             id_we_in, id_dst_in, id_load_in, redirect_in,
      output stall_out, pc_hold_out, flush_if_out, flush_id_out,
             fwd_sel_a_out, fwd_sel_b_out, stage_valid_out,
             stall_count_out, flush_count_out
   );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: hazard, bypass-select and redirect-flush controller for the in-order core.
// Latency: all control/forward outputs are combinational (zero cycles); counters update on the clock.
// Backpressure: stall_out holds IF/ID, pc_hold_out holds the PC; the tracked entries always shift.
//
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : ID operand/destination info and redirect in; stall, flush,
//                  forward selects, per-entry valid bits and stall/flush counters out
module hazard_pipe_ctrl #(
   parameter int REG_W      = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2,
   parameter int FWD_EN     = 1,
   parameter int DELAY_SLOT = 1,
   parameter int CNT_W      = 32
) (
   input logic               clock,
   input logic               reset,
   hazard_pipe_ctrl_if.slave bus
);

   typedef struct packed {
      logic             valid;
      logic             we;
      logic             load;
      logic [REG_W-1:0] dst;
   } entry_t;

   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam bit               SquashSlot = (DELAY_SLOT == 0);

   entry_t           entryQ [DEPTH];
   logic [DEPTH-1:0] matchA;
   logic [DEPTH-1:0] matchB;
   logic [DEPTH-1:0] stageValid;
   logic [2:0]       selA;
   logic [2:0]       selB;
   logic             hazardA;
   logic             hazardB;
   logic             hazard;
   logic             redirectEff;
   logic             stall;
   logic             flushId;
   logic             validIssue;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   // A redirect only means something when entry 0 holds a real branch/jump.
   assign redirectEff = bus.redirect_in & entryQ[0].valid;

   // Register 0 is hard-wired zero, so it never creates a dependency.
   always_comb begin
      matchA     = '0;
      matchB     = '0;
      stageValid = '0;
      for (int k = 0; k < DEPTH; k++) begin
         matchA[k]     = entryQ[k].valid & entryQ[k].we & (entryQ[k].dst == bus.id_rs_in)
                       & (bus.id_rs_in != '0) & bus.id_use_rs_in;
         matchB[k]     = entryQ[k].valid & entryQ[k].we & (entryQ[k].dst == bus.id_rt_in)
                       & (bus.id_rt_in != '0) & bus.id_use_rt_in;
         stageValid[k] = entryQ[k].valid;
      end
   end

   // With bypassing, the youngest producer wins; scanning oldest-to-youngest lets
   // the lowest index overwrite. A load is only a hazard while its data is not
   // yet available (entry index below LOAD_STAGE).
   // Without bypassing, any producer still ahead of writeback blocks; writeback
   // itself is covered by the register file's write-then-read.
   always_comb begin
      selA    = '0;
      selB    = '0;
      hazardA = 1'b0;
      hazardB = 1'b0;
      if (FWD_EN != 0) begin
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (matchA[k]) begin
               selA    = 3'(k + 1);
               hazardA = entryQ[k].load & (k < LOAD_STAGE);
            end
            if (matchB[k]) begin
               selB    = 3'(k + 1);
               hazardB = entryQ[k].load & (k < LOAD_STAGE);
            end
         end
      end else begin
         hazardA = |matchA[DEPTH-2:0];
         hazardB = |matchB[DEPTH-2:0];
      end
   end

   assign hazard = hazardA | hazardB;

   // When the ID instruction is being squashed anyway, holding it is pointless.
   assign stall      = bus.id_valid_in & hazard & ~(redirectEff & SquashSlot);
   assign flushId    = redirectEff & SquashSlot;
   assign validIssue = bus.id_valid_in & ~stall & ~flushId;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            entryQ[k] <= '0;
         end
      end else begin
         if (validIssue) begin
            entryQ[0].valid <= 1'b1;
            entryQ[0].we    <= bus.id_we_in;
            entryQ[0].load  <= bus.id_load_in;
            entryQ[0].dst   <= bus.id_dst_in;
         end else begin
            entryQ[0] <= '0;
         end
         for (int k = 1; k < DEPTH; k++) begin
            entryQ[k] <= entryQ[k-1];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stallCnt <= '0;
         flushCnt <= '0;
      end else begin
         if (stall && (stallCnt != CntMax)) begin
            stallCnt <= stallCnt + CntOne;
         end
         if (redirectEff && (flushCnt != CntMax)) begin
            flushCnt <= flushCnt + CntOne;
         end
      end
   end

   assign bus.stall_out       = stall;
   assign bus.pc_hold_out     = stall & ~redirectEff;
   assign bus.flush_if_out    = redirectEff;
   assign bus.flush_id_out    = flushId;
   assign bus.fwd_sel_a_out   = selA;
   assign bus.fwd_sel_b_out   = selB;
   assign bus.stage_valid_out = stageValid;
   assign bus.stall_count_out = stallCnt;
   assign bus.flush_count_out = flushCnt;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: checks two controller builds fed identical ID streams.
// u0: bypassing + delay slot, 32-bit counters; u1: no bypassing, squashed slot, 3-bit counters.
// Expected outputs come from a behavioural model and are queued per cycle.
module tb_hazard_pipe_ctrl;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   hazard_pipe_ctrl_if #(.REG_W(5), .DEPTH(3), .CNT_W(32)) bus0 ();
   hazard_pipe_ctrl_if #(.REG_W(5), .DEPTH(3), .CNT_W(3))  bus1 ();

   hazard_pipe_ctrl #(
      .REG_W(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_EN(1), .DELAY_SLOT(1), .CNT_W(32)
   ) u0 (
      .clock(clock),
      .reset(reset),
      .bus  (bus0)
   );

   hazard_pipe_ctrl #(
      .REG_W(5), .DEPTH(3), .LOAD_STAGE(2), .FWD_EN(0), .DELAY_SLOT(0), .CNT_W(3)
   ) u1 (
      .clock(clock),
      .reset(reset),
      .bus  (bus1)
   );

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic       useRs;
      logic [4:0] rt;
      logic       useRt;
      logic       we;
      logic [4:0] dst;
      logic       load;
      logic       redirect;
   } idIn_t;

   typedef struct {
      logic        stall;
      logic        pcHold;
      logic        flushIf;
      logic        flushId;
      logic [2:0]  fwdA;
      logic [2:0]  fwdB;
      logic [2:0]  stageValid;
      logic [63:0] stallCnt;
      logic [63:0] flushCnt;
   } exp_t;

   int nChecks = 0;
   int nFails  = 0;

   // Per-build model configuration.
   int          pFwd [2] = '{1, 0};
   int          pDs  [2] = '{1, 0};
   logic [63:0] pMax [2] = '{64'hFFFF_FFFF, 64'h7};

   logic        mV   [2][3];
   logic        mWe  [2][3];
   logic        mLd  [2][3];
   logic [4:0]  mDst [2][3];
   logic [63:0] mSc  [2];
   logic [63:0] mFc  [2];
   logic        mIssue [2];
   logic        mStl   [2];
   logic        mRed   [2];
   idIn_t       curIn;

   exp_t q0 [$];
   exp_t q1 [$];

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic idIn_t mk(input logic valid, input int rs, input logic useRs,
                                input int rt, input logic useRt, input logic we,
                                input int dst, input logic load, input logic redirect);
      idIn_t x;
      x.valid    = valid;
      x.rs       = 5'(rs);
      x.useRs    = useRs;
      x.rt       = 5'(rt);
      x.useRt    = useRt;
      x.we       = we;
      x.dst      = 5'(dst);
      x.load     = load;
      x.redirect = redirect;
      return x;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 3; k++) begin
            mV[i][k]   = 1'b0;
            mWe[i][k]  = 1'b0;
            mLd[i][k]  = 1'b0;
            mDst[i][k] = '0;
         end
         mSc[i]    = '0;
         mFc[i]    = '0;
         mIssue[i] = 1'b0;
         mStl[i]   = 1'b0;
         mRed[i]   = 1'b0;
      end
      curIn = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Scan young-to-old; the first producer found decides forwarding/load-use.
   task automatic opnd(input int i, input logic [4:0] src, input logic useSrc,
                       output logic [2:0] sel, output logic haz);
      logic found;
      logic hit;
      found = 1'b0;
      sel   = '0;
      haz   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         hit = mV[i][k] && mWe[i][k] && (mDst[i][k] == src) && (src != 5'd0) && useSrc;
         if (hit && !found) begin
            found = 1'b1;
            if (pFwd[i] != 0) begin
               sel = 3'(k + 1);
               haz = mLd[i][k] && (k < 2);
            end
         end
         if (hit && (pFwd[i] == 0) && (k <= 1)) haz = 1'b1;
      end
   endtask

   task automatic evalModel(input int i, input idIn_t x, output exp_t e);
      logic redir;
      logic hA;
      logic hB;
      redir = x.redirect && mV[i][0];
      opnd(i, x.rs, x.useRs, e.fwdA, hA);
      opnd(i, x.rt, x.useRt, e.fwdB, hB);
      e.stall      = x.valid && (hA || hB) && !(redir && (pDs[i] == 0));
      e.pcHold     = e.stall && !redir;
      e.flushIf    = redir;
      e.flushId    = redir && (pDs[i] == 0);
      e.stageValid = {mV[i][2], mV[i][1], mV[i][0]};
      e.stallCnt   = mSc[i];
      e.flushCnt   = mFc[i];
      mIssue[i]    = x.valid && !e.stall && !e.flushId;
      mStl[i]      = e.stall;
      mRed[i]      = redir;
   endtask

   task automatic advance(input int i);
      if (mStl[i] && (mSc[i] != pMax[i])) mSc[i] = mSc[i] + 1;
      if (mRed[i] && (mFc[i] != pMax[i])) mFc[i] = mFc[i] + 1;
      for (int k = 2; k >= 1; k--) begin
         mV[i][k]   = mV[i][k-1];
         mWe[i][k]  = mWe[i][k-1];
         mLd[i][k]  = mLd[i][k-1];
         mDst[i][k] = mDst[i][k-1];
      end
      mV[i][0]   = mIssue[i];
      mWe[i][0]  = curIn.we;
      mLd[i][0]  = curIn.load;
      mDst[i][0] = curIn.dst;
   endtask

   task automatic drive(input idIn_t x);
      bus0.id_valid_in  = x.valid;
      bus0.id_rs_in     = x.rs;
      bus0.id_rt_in     = x.rt;
      bus0.id_use_rs_in = x.useRs;
      bus0.id_use_rt_in = x.useRt;
      bus0.id_we_in     = x.we;
      bus0.id_dst_in    = x.dst;
      bus0.id_load_in   = x.load;
      bus0.redirect_in  = x.redirect;
      bus1.id_valid_in  = x.valid;
      bus1.id_rs_in     = x.rs;
      bus1.id_rt_in     = x.rt;
      bus1.id_use_rs_in = x.useRs;
      bus1.id_use_rt_in = x.useRt;
      bus1.id_we_in     = x.we;
      bus1.id_dst_in    = x.dst;
      bus1.id_load_in   = x.load;
      bus1.redirect_in  = x.redirect;
   endtask

   task automatic compareOut(input int i, input exp_t e);
      exp_t o;
      if (i == 0) begin
         o.stall      = bus0.stall_out;
         o.pcHold     = bus0.pc_hold_out;
         o.flushIf    = bus0.flush_if_out;
         o.flushId    = bus0.flush_id_out;
         o.fwdA       = bus0.fwd_sel_a_out;
         o.fwdB       = bus0.fwd_sel_b_out;
         o.stageValid = bus0.stage_valid_out;
         o.stallCnt   = 64'(bus0.stall_count_out);
         o.flushCnt   = 64'(bus0.flush_count_out);
      end else begin
         o.stall      = bus1.stall_out;
         o.pcHold     = bus1.pc_hold_out;
         o.flushIf    = bus1.flush_if_out;
         o.flushId    = bus1.flush_id_out;
         o.fwdA       = bus1.fwd_sel_a_out;
         o.fwdB       = bus1.fwd_sel_b_out;
         o.stageValid = bus1.stage_valid_out;
         o.stallCnt   = 64'(bus1.stall_count_out);
         o.flushCnt   = 64'(bus1.flush_count_out);
      end
      checkVal($sformatf("u%0d_stall", i),      o.stall,      e.stall);
      checkVal($sformatf("u%0d_pc_hold", i),    o.pcHold,     e.pcHold);
      checkVal($sformatf("u%0d_flush_if", i),   o.flushIf,    e.flushIf);
      checkVal($sformatf("u%0d_flush_id", i),   o.flushId,    e.flushId);
      checkVal($sformatf("u%0d_fwd_a", i),      o.fwdA,       e.fwdA);
      checkVal($sformatf("u%0d_fwd_b", i),      o.fwdB,       e.fwdB);
      checkVal($sformatf("u%0d_stage_vld", i),  o.stageValid, e.stageValid);
      checkVal($sformatf("u%0d_stall_cnt", i),  o.stallCnt,   e.stallCnt);
      checkVal($sformatf("u%0d_flush_cnt", i),  o.flushCnt,   e.flushCnt);
   endtask

   task automatic popCompare();
      if (q0.size() == 0) checkVal("sb0_underflow", 0, 1);
      else                compareOut(0, q0.pop_front());
      if (q1.size() == 0) checkVal("sb1_underflow", 0, 1);
      else                compareOut(1, q1.pop_front());
   endtask

   // One cycle: model absorbs the edge, new ID info is driven, outputs are checked
   // at the falling edge. Returns at the falling edge so directed checks can follow.
   task automatic step(input idIn_t x);
      exp_t e;
      @(posedge clock);
      advance(0);
      advance(1);
      #1;
      drive(x);
      curIn = x;
      evalModel(0, x, e);
      q0.push_back(e);
      evalModel(1, x, e);
      q1.push_back(e);
      @(negedge clock);
      popCompare();
   endtask

   task automatic checkAllZero(input string tag);
      checkVal({tag, "_u0_stall"},     bus0.stall_out,       0);
      checkVal({tag, "_u0_pc_hold"},   bus0.pc_hold_out,     0);
      checkVal({tag, "_u0_flush_if"},  bus0.flush_if_out,    0);
      checkVal({tag, "_u0_flush_id"},  bus0.flush_id_out,    0);
      checkVal({tag, "_u0_fwd_a"},     bus0.fwd_sel_a_out,   0);
      checkVal({tag, "_u0_fwd_b"},     bus0.fwd_sel_b_out,   0);
      checkVal({tag, "_u0_stage_vld"}, bus0.stage_valid_out, 0);
      checkVal({tag, "_u0_stall_cnt"}, bus0.stall_count_out, 0);
      checkVal({tag, "_u0_flush_cnt"}, bus0.flush_count_out, 0);
      checkVal({tag, "_u1_stall"},     bus1.stall_out,       0);
      checkVal({tag, "_u1_flush_if"},  bus1.flush_if_out,    0);
      checkVal({tag, "_u1_stage_vld"}, bus1.stage_valid_out, 0);
      checkVal({tag, "_u1_stall_cnt"}, bus1.stall_count_out, 0);
   endtask

   initial begin
      idIn_t x;

      // Reset with an aggressive ID instruction present: everything must read 0.
      reset = 1'b1;
      modelReset();
      drive(mk(1, 3, 1, 3, 1, 1, 3, 1, 1));
      #3;
      checkAllZero("reset");
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clock);
      reset = 1'b0;

      // Back-to-back dependency on r3.
      step(mk(1, 0, 0, 0, 0, 1, 3, 0, 0));
      step(mk(1, 3, 1, 0, 0, 0, 0, 0, 0));
      checkVal("b2b_u0_fwd_a_1", bus0.fwd_sel_a_out, 1);
      checkVal("b2b_u0_no_stall", bus0.stall_out, 0);
      checkVal("nofwd_u1_stall_c1", bus1.stall_out, 1);
      step(mk(1, 3, 1, 0, 0, 0, 0, 0, 0));
      checkVal("b2b_u0_fwd_a_2", bus0.fwd_sel_a_out, 2);
      checkVal("nofwd_u1_stall_c2", bus1.stall_out, 1);
      checkVal("nofwd_u1_fwd_a", bus1.fwd_sel_a_out, 0);
      step(mk(1, 3, 1, 0, 0, 0, 0, 0, 0));
      checkVal("b2b_u0_fwd_a_3", bus0.fwd_sel_a_out, 3);
      checkVal("nofwd_u1_release", bus1.stall_out, 0);

      // Load-use on r5 through source B.
      step(mk(1, 0, 0, 0, 0, 1, 5, 1, 0));
      step(mk(1, 0, 0, 5, 1, 0, 0, 0, 0));
      checkVal("ldu_u0_stall_c1", bus0.stall_out, 1);
      checkVal("ldu_u0_pc_hold_c1", bus0.pc_hold_out, 1);
      step(mk(1, 0, 0, 5, 1, 0, 0, 0, 0));
      checkVal("ldu_u0_stall_c2", bus0.stall_out, 1);
      checkVal("ldu_u0_bubble_e0", bus0.stage_valid_out[0], 0);
      step(mk(1, 0, 0, 5, 1, 0, 0, 0, 0));
      checkVal("ldu_u0_stall_c3", bus0.stall_out, 0);
      checkVal("ldu_u0_fwd_b_3", bus0.fwd_sel_b_out, 3);
      checkVal("ldu_u0_stall_cnt", bus0.stall_count_out, 2);

      // r0 producer and unused operands never match.
      step(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
      step(mk(1, 0, 1, 0, 1, 0, 0, 0, 0));
      checkVal("r0_u0_fwd_a", bus0.fwd_sel_a_out, 0);
      checkVal("r0_u0_stall", bus0.stall_out, 0);
      checkVal("r0_u1_stall", bus1.stall_out, 0);
      step(mk(1, 0, 0, 0, 0, 1, 9, 1, 0));
      step(mk(1, 9, 0, 9, 0, 0, 0, 0, 0));
      checkVal("unused_u0_fwd_a", bus0.fwd_sel_a_out, 0);
      checkVal("unused_u0_stall", bus0.stall_out, 0);
      checkVal("unused_u1_stall", bus1.stall_out, 0);

      // Redirect resolved by the branch in entry 0, delay-slot candidate in ID.
      step(mk(1, 0, 0, 0, 0, 1, 10, 0, 0));
      step(mk(1, 0, 0, 0, 0, 1, 11, 0, 1));
      checkVal("redir_u0_flush_if", bus0.flush_if_out, 1);
      checkVal("redir_u0_flush_id", bus0.flush_id_out, 0);
      checkVal("redir_u1_flush_if", bus1.flush_if_out, 1);
      checkVal("redir_u1_flush_id", bus1.flush_id_out, 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkVal("redir_u0_slot_issued", bus0.stage_valid_out[0], 1);
      checkVal("redir_u1_slot_squashed", bus1.stage_valid_out[0], 0);
      checkVal("redir_u0_flush_cnt", bus0.flush_count_out, 1);
      checkVal("redir_u1_flush_cnt", bus1.flush_count_out, 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
      checkVal("redir_ignored_u0", bus0.flush_if_out, 0);
      checkVal("redir_ignored_u1", bus1.flush_if_out, 0);

      // Random traffic over a small register set to provoke overlapping hazards.
      for (int n = 0; n < 400; n++) begin
         x.valid    = ($urandom_range(0, 3) != 0);
         x.rs       = 5'($urandom_range(0, 3));
         x.useRs    = 1'($urandom_range(0, 1));
         x.rt       = 5'($urandom_range(0, 3));
         x.useRt    = 1'($urandom_range(0, 1));
         x.we       = ($urandom_range(0, 3) != 0);
         x.dst      = 5'($urandom_range(0, 3));
         x.load     = ($urandom_range(0, 2) == 0);
         x.redirect = ($urandom_range(0, 4) == 0);
         step(x);
      end
      checkVal("u1_stall_cnt_saturated", bus1.stall_count_out, 7);

      // Asynchronous reset in the middle of a load-use stall.
      step(mk(1, 0, 0, 0, 0, 1, 5, 1, 0));
      step(mk(1, 0, 0, 5, 1, 0, 0, 0, 0));
      checkVal("mid_rst_pre_stall", bus0.stall_out, 1);
      #2;
      reset = 1'b1;
      #1;
      checkVal("mid_rst_u0_stage_vld", bus0.stage_valid_out, 0);
      checkVal("mid_rst_u0_stall", bus0.stall_out, 0);
      checkVal("mid_rst_u0_stall_cnt", bus0.stall_count_out, 0);
      checkVal("mid_rst_u0_flush_cnt", bus0.flush_count_out, 0);
      checkVal("mid_rst_u1_stage_vld", bus1.stage_valid_out, 0);
      checkVal("mid_rst_u1_stall_cnt", bus1.stall_count_out, 0);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      modelReset();
      @(negedge clock);
      reset = 1'b0;

      // Traffic after reset starts from a clean pipe.
      step(mk(1, 0, 0, 0, 0, 1, 3, 0, 0));
      step(mk(1, 3, 1, 3, 1, 0, 0, 0, 0));
      checkVal("post_rst_u0_fwd_a", bus0.fwd_sel_a_out, 1);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
